// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and types for the 3x3 window generator
package conv_pkg;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t [K*K-1:0] window_t;
endpackage

// File: rtl/conv_line_buf.sv
// rtl/conv_line_buf.sv - two-row line buffer, one column read and shifted per accepted pixel
module conv_line_buf
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] idx,
    input  pixel_t           din,
    output pixel_t           top,
    output pixel_t           mid
);
    // Storage carries no reset; the top gates stale columns out of every window.
    pixel_t older_q [IMG_W];
    pixel_t newer_q [IMG_W];

    assign top = older_q[idx];
    assign mid = newer_q[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            older_q[idx] <= newer_q[idx];
            newer_q[idx] <= din;
        end
    end
endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 window generator; CONV_WIN_SOF_CHECK_EN adds in_sof/err
module conv_window_gen
    import conv_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [K*K*DATA_W-1:0]     out_window,
    output logic [ROW_W-1:0]          out_row,
    output logic [COL_W-1:0]          out_col,
    output logic                      out_last
`ifdef CONV_WIN_SOF_CHECK_EN
    ,
    input  logic                      in_sof,
    output logic                      err
`endif
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col_q, cur_col;
    logic [ROW_W-1:0] row_q, cur_row;
    logic             accept, emit, sof_hit;
    pixel_t           lb_top, lb_mid;
    window_t          win_q, win_next;

`ifdef CONV_WIN_SOF_CHECK_EN
    assign sof_hit = in_sof;
`else
    assign sof_hit = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // A start-of-frame pixel is treated as (0,0) regardless of the counters.
    assign cur_col  = sof_hit ? '0 : col_q;
    assign cur_row  = sof_hit ? '0 : row_q;
    assign emit     = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

    conv_line_buf u_line_buf (
        .clk (clk),
        .we  (accept),
        .idx (cur_col),
        .din (pixel_t'(in_pixel)),
        .top (lb_top),
        .mid (lb_mid)
    );

    // Shift the window left one column and bring in {row r-2, row r-1, new pixel} on the right.
    always_comb begin
        win_next = win_q;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_next[i*K + j] = win_q[i*K + j + 1];
            end
        end
        win_next[0*K + K - 1] = lb_top;
        win_next[1*K + K - 1] = lb_mid;
        win_next[2*K + K - 1] = pixel_t'(in_pixel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_next;
            if (cur_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_q <= cur_col + COL_W'(1);
                row_q <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            out_window <= win_next;
            out_row    <= cur_row - ROW_TWO;
            out_col    <= cur_col - COL_TWO;
            out_last   <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef CONV_WIN_SOF_CHECK_EN
    // Sticky framing error: SOF away from (0,0), or (0,0) reached without SOF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            if (in_sof && ((col_q != '0) || (row_q != '0))) begin
                err <= 1'b1;
            end else if (!in_sof && (col_q == '0) && (row_q == '0)) begin
                err <= 1'b1;
            end
        end
    end
`endif
endmodule
